// File: rtl/systolic_array_nxn_pkg.sv
// Shared types and constants for the N x N output-stationary systolic array.
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

   // Accumulator width that cannot overflow for k_len <= k_max.
   function automatic int acc_w_default(input int data_w, input int k_max);
      return 2 * data_w + $clog2(k_max);
   endfunction

   // Zero-injection advances needed to flush the skewed wavefront through the array.
   function automatic int drain_cycles(input int n);
      return 2 * n - 2;
   endfunction

endpackage

// File: rtl/systolic_array_nxn_if.sv
// Operand-beat and result-row handshake bundle of the systolic array.
interface systolic_array_nxn_if
   import systolic_pkg::*;
#(
   parameter int N      = 4,
   parameter int DATA_W = 8,
   parameter int K_MAX  = 256,
   parameter int ACC_W  = acc_w_default(DATA_W, K_MAX)
);
   logic                  in_valid;
   logic                  in_ready;
   logic [N*DATA_W-1:0]   a_col;
   logic [N*DATA_W-1:0]   b_row;
   logic                  out_valid;
   logic                  out_ready;
   logic [$clog2(N)-1:0]  out_row;
   logic [N*ACC_W-1:0]    out_data;

   modport master (
      output in_valid, a_col, b_row, out_ready,
      input  in_ready, out_valid, out_row, out_data
   );

   modport slave (
      input  in_valid, a_col, b_row, out_ready,
      output in_ready, out_valid, out_row, out_data
   );
endinterface

// File: rtl/systolic_array_nxn_pe.sv
// One multiply-accumulate cell: forwards A right and B down, accumulates on each advance.
module systolic_pe #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              adv,
   input  logic              clr,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [ACC_W-1:0]  acc
);
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [2*DATA_W-1:0] prod;

   // Clear wins over advance; otherwise hold so stalled beats are lossless.
   always_comb begin
      prod  = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      if (clr) begin
         a_d   = '0;
         b_d   = '0;
         acc_d = '0;
      end else if (adv) begin
         a_d   = a_in;
         b_d   = b_in;
         acc_d = acc_q + ACC_W'(prod);
      end
   end

   // Cell state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
      end
   end

   assign a_out = a_q;
   assign b_out = b_q;
   assign acc   = acc_q;
endmodule

// File: rtl/systolic_array_nxn.sv
// N x N output-stationary matrix-multiply engine with input skew, drain and row readout.
//
//  state | meaning
//  IDLE  | waiting for start; start clears array and latches k_len
//  FEED  | accepting k_len operand beats, one advance per fire
//  DRAIN | 2N-2 zero-injection advances to finish the wavefront
//  OUT   | presenting result rows 0..N-1, one per out handshake
module systolic_array_nxn
   import systolic_pkg::*;
#(
   parameter int N      = 4,
   parameter int DATA_W = 8,
   parameter int K_MAX  = 256,
   parameter int ACC_W  = acc_w_default(DATA_W, K_MAX)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [$clog2(K_MAX+1)-1:0] k_len,
   output logic                       busy,
   output logic                       done,
   systolic_array_nxn_if.slave        bus
);
   localparam int KW = $clog2(K_MAX + 1);
   localparam int DW = $clog2(2 * N);
   localparam int RW = $clog2(N);
   localparam logic [DW-1:0] DRAIN_N = DW'(drain_cycles(N));

   state_t            state_q, state_d;
   logic [KW-1:0]     k_cnt_q, k_cnt_d;
   logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
   logic [RW-1:0]     out_row_q, out_row_d;
   logic [N*ACC_W-1:0] out_data_q, out_data_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic feed_fire, out_fire, adv, clr;

   logic [DATA_W-1:0] a_lane [N];
   logic [DATA_W-1:0] b_lane [N];
   logic [DATA_W-1:0] a_edge [N];
   logic [DATA_W-1:0] b_edge [N];
   logic [DATA_W-1:0] a_fwd  [N][N];
   logic [DATA_W-1:0] b_fwd  [N][N];
   logic [ACC_W-1:0]  acc    [N][N];

   assign feed_fire = (state_q == FEED) && bus.in_valid;
   assign out_fire  = out_valid_q && bus.out_ready;
   assign adv       = feed_fire || (state_q == DRAIN);
   assign clr       = (state_q == IDLE) && start;

   // Operand lanes; zeros are injected outside FEED so the drain flushes cleanly.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         a_lane[i] = '0;
         b_lane[i] = '0;
         if (state_q == FEED) begin
            a_lane[i] = bus.a_col[i*DATA_W +: DATA_W];
            b_lane[i] = bus.b_row[i*DATA_W +: DATA_W];
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_skew
      if (gi == 0) begin : g_direct
         assign a_edge[gi] = a_lane[gi];
         assign b_edge[gi] = b_lane[gi];
      end else begin : g_dly
         logic [DATA_W-1:0] sa_q [gi];
         logic [DATA_W-1:0] sa_d [gi];
         logic [DATA_W-1:0] sb_q [gi];
         logic [DATA_W-1:0] sb_d [gi];

         // Lane gi is delayed by gi advances; shifts only when the array advances.
         always_comb begin
            for (int s = 0; s < gi; s++) begin
               sa_d[s] = sa_q[s];
               sb_d[s] = sb_q[s];
            end
            if (clr) begin
               for (int s = 0; s < gi; s++) begin
                  sa_d[s] = '0;
                  sb_d[s] = '0;
               end
            end else if (adv) begin
               sa_d[0] = a_lane[gi];
               sb_d[0] = b_lane[gi];
               for (int s = 1; s < gi; s++) begin
                  sa_d[s] = sa_q[s-1];
                  sb_d[s] = sb_q[s-1];
               end
            end
         end

         // Skew shift registers.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int s = 0; s < gi; s++) begin
                  sa_q[s] <= '0;
                  sb_q[s] <= '0;
               end
            end else begin
               for (int s = 0; s < gi; s++) begin
                  sa_q[s] <= sa_d[s];
                  sb_q[s] <= sb_d[s];
               end
            end
         end

         assign a_edge[gi] = sa_q[gi-1];
         assign b_edge[gi] = sb_q[gi-1];
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_col
         logic [DATA_W-1:0] a_src, b_src;
         if (gj == 0) begin : g_a_edge
            assign a_src = a_edge[gi];
         end else begin : g_a_fwd
            assign a_src = a_fwd[gi][gj-1];
         end
         if (gi == 0) begin : g_b_edge
            assign b_src = b_edge[gj];
         end else begin : g_b_fwd
            assign b_src = b_fwd[gi-1][gj];
         end

         systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
            .clk   (clk),
            .rst   (rst),
            .adv   (adv),
            .clr   (clr),
            .a_in  (a_src),
            .b_in  (b_src),
            .a_out (a_fwd[gi][gj]),
            .b_out (b_fwd[gi][gj]),
            .acc   (acc[gi][gj])
         );
      end
   end

   // FSM next state with beat down-counter and drain down-counter.
   always_comb begin
      state_d     = state_q;
      k_cnt_d     = k_cnt_q;
      drain_cnt_d = drain_cnt_q;
      out_row_d   = out_row_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = FEED;
               k_cnt_d   = (k_len == '0) ? KW'(1) : k_len;
               out_row_d = '0;
            end
         end
         FEED: begin
            if (feed_fire) begin
               if (k_cnt_q == KW'(1)) begin
                  state_d     = DRAIN;
                  drain_cnt_d = DRAIN_N;
               end else begin
                  k_cnt_d = k_cnt_q - KW'(1);
               end
            end
         end
         DRAIN: begin
            if (drain_cnt_q == DW'(1)) begin
               state_d   = OUT;
               out_row_d = '0;
            end else begin
               drain_cnt_d = drain_cnt_q - DW'(1);
            end
         end
         OUT: begin
            if (out_fire) begin
               if (out_row_q == RW'(N - 1)) begin
                  state_d   = IDLE;
                  out_row_d = '0;
               end else begin
                  out_row_d = out_row_q + RW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs derived from the next state. Row 0 is already final when
   // OUT is entered, since only the bottom-right corner still accumulates on the last drain advance.
   always_comb begin
      in_ready_d  = (state_d == FEED);
      out_valid_d = (state_d == OUT);
      busy_d      = (state_d != IDLE);
      done_d      = (state_q == OUT) && (state_d == IDLE);
      out_data_d  = '0;
      if (state_d == OUT) begin
         for (int j = 0; j < N; j++) begin
            out_data_d[j*ACC_W +: ACC_W] = acc[out_row_d][j];
         end
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         k_cnt_q     <= '0;
         drain_cnt_q <= '0;
         out_row_q   <= '0;
         out_data_q  <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_cnt_q     <= k_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         out_row_q   <= out_row_d;
         out_data_q  <= out_data_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_row   = out_row_q;
   assign bus.out_data  = out_data_q;
   assign busy          = busy_q;
   assign done          = done_q;
endmodule

// File: tb/tb_systolic_array_nxn.sv
// Self-checking bench for systolic_array_nxn against a plain matrix-product model.
module tb_systolic_array_nxn;
   localparam int N      = 4;
   localparam int DATA_W = 8;
   localparam int K_MAX  = 256;
   localparam int ACC_W  = 24;
   localparam int KW     = $clog2(K_MAX + 1);

   logic          clk;
   logic          rst;
   logic          start;
   logic [KW-1:0] k_len;
   logic          busy;
   logic          done;

   systolic_array_nxn_if #(.N(N), .DATA_W(DATA_W), .K_MAX(K_MAX), .ACC_W(ACC_W)) bus ();

   systolic_array_nxn #(.N(N), .DATA_W(DATA_W), .K_MAX(K_MAX), .ACC_W(ACC_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .k_len (k_len),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
   );

   int vectors;
   int miscompares;
   int done_cnt;

   int unsigned a_m [N][K_MAX];
   int unsigned b_m [K_MAX][N];
   logic [ACC_W-1:0] exp_c [N][N];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_random(input int k);
      for (int i = 0; i < N; i++)
         for (int kk = 0; kk < k; kk++) begin
            a_m[i][kk] = $urandom_range(0, 255);
            b_m[kk][i] = $urandom_range(0, 255);
         end
   endtask

   task automatic fill_const(input int k, input int unsigned v);
      for (int i = 0; i < N; i++)
         for (int kk = 0; kk < k; kk++) begin
            a_m[i][kk] = v;
            b_m[kk][i] = v;
         end
   endtask

   // Plain C = A*B, truncated to the accumulator width.
   task automatic model(input int k);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            longint s = 0;
            for (int kk = 0; kk < k; kk++) s += longint'(a_m[i][kk]) * longint'(b_m[kk][j]);
            exp_c[i][j] = ACC_W'(s);
         end
   endtask

   // gap: 0 = in_valid held high, 1 = toggled 1-0-1-0, 2 = random
   task automatic run_job(input string name, input int klen_in, input int gap,
                          input int stall_row, input bit poke);
      int eff, fired, cyc, guard, d0;
      bit tog;
      logic [N*ACC_W-1:0] er;
      eff = (klen_in == 0) ? 1 : klen_in;
      model(eff);
      d0 = done_cnt;
      start = 1'b1;
      k_len = KW'(klen_in);
      tick();
      start = 1'b0;
      cyc = 1; fired = 0; guard = 0; tog = 1'b1;
      while (fired < eff && guard < 4000) begin
         bus.in_valid = (gap == 0) ? 1'b1 : (gap == 1) ? tog : 1'($urandom_range(0, 1));
         tog = ~tog;
         for (int i = 0; i < N; i++) begin
            bus.a_col[i*DATA_W +: DATA_W] = DATA_W'(a_m[i][fired]);
            bus.b_row[i*DATA_W +: DATA_W] = DATA_W'(b_m[fired][i]);
         end
         vectors++;
         if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s in_ready_feed: got %b want 1 (beat %0d)", name, bus.in_ready, fired);
         end
         start = (poke && fired == 1) ? 1'b1 : 1'b0;
         tick();
         start = 1'b0;
         cyc++; guard++;
         if (bus.in_valid) fired++;
         if (poke) begin
            vectors++;
            if (busy !== 1'b1) begin
               miscompares++;
               $display("FAIL %s busy_after_poke: got %b want 1", name, busy);
            end
         end
      end
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL %s in_ready_after_last: got %b want 0", name, bus.in_ready);
      end
      guard = 0;
      while (bus.out_valid !== 1'b1 && guard < 200) begin
         tick();
         cyc++; guard++;
      end
      vectors++;
      if (bus.out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL %s out_valid_timeout: got %b want 1", name, bus.out_valid);
         return;
      end
      if (gap == 0) begin
         vectors++;
         if (cyc != eff + 2*N - 1) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, eff + 2*N - 1);
         end
      end
      bus.out_ready = 1'b1;
      for (int r = 0; r < N; r++) begin
         for (int j = 0; j < N; j++) er[j*ACC_W +: ACC_W] = exp_c[r][j];
         vectors++;
         if (bus.out_valid !== 1'b1 || bus.out_row !== 2'(r) || bus.out_data !== er) begin
            miscompares++;
            $display("FAIL %s row%0d: got v=%b row=%0d data=%h want v=1 row=%0d data=%h",
                     name, r, bus.out_valid, bus.out_row, bus.out_data, r, er);
         end
         if (r == stall_row) begin
            bus.out_ready = 1'b0;
            repeat (5) begin
               tick();
               vectors++;
               if (bus.out_valid !== 1'b1 || bus.out_row !== 2'(r) || bus.out_data !== er) begin
                  miscompares++;
                  $display("FAIL %s stall_row%0d: got v=%b row=%0d data=%h want v=1 row=%0d data=%h",
                           name, r, bus.out_valid, bus.out_row, bus.out_data, r, er);
               end
            end
            bus.out_ready = 1'b1;
         end
         start = (poke && r == 0) ? 1'b1 : 1'b0;
         tick();
         start = 1'b0;
      end
      bus.out_ready = 1'b0;
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL %s done_pulse: got done=%b busy=%b ov=%b want done=1 busy=0 ov=0",
                  name, done, busy, bus.out_valid);
      end
      tick();
      vectors++;
      if (done !== 1'b0 || done_cnt - d0 != 1) begin
         miscompares++;
         $display("FAIL %s done_once: got done=%b count=%0d want done=0 count=1", name, done, done_cnt - d0);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      vectors++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_row !== '0 ||
          bus.out_data !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL %s outputs: got ir=%b ov=%b row=%0d data=%h busy=%b done=%b want all zero",
                  name, bus.in_ready, bus.out_valid, bus.out_row, bus.out_data, busy, done);
      end
   endtask

   task automatic test_reset();
      check_idle_outputs("reset");
   endtask

   task automatic test_identity();
      fill_const(2, 0);
      for (int i = 0; i < N; i++) begin
         a_m[i][0] = 2*i + 1;
         a_m[i][1] = 2*i + 2;
      end
      b_m[0][0] = 1;
      b_m[1][1] = 1;
      run_job("identity", 2, 0, -1, 1'b0);
   endtask

   task automatic test_max_operands();
      fill_const(4, 255);
      run_job("all255_k4", 4, 0, -1, 1'b0);
      fill_const(K_MAX, 255);
      run_job("all255_kmax", K_MAX, 0, -1, 1'b0);
   endtask

   task automatic test_bubbles();
      fill_random(3);
      run_job("bubbles_gapless", 3, 0, -1, 1'b0);
      run_job("bubbles_toggled", 3, 1, -1, 1'b0);
   endtask

   task automatic test_out_stall();
      fill_random(5);
      run_job("out_stall", 5, 0, 1, 1'b0);
   endtask

   task automatic test_start_ignored();
      fill_random(4);
      run_job("start_ignored", 4, 0, -1, 1'b1);
   endtask

   task automatic test_k_zero();
      fill_random(1);
      run_job("k_zero", 0, 0, -1, 1'b0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 6; t++) begin
         int k;
         k = $urandom_range(1, 20);
         fill_random(k);
         run_job($sformatf("random%0d", t), k, 2, $urandom_range(0, N-1), 1'b0);
      end
   endtask

   task automatic test_reset_midfeed();
      int d0;
      d0 = done_cnt;
      fill_random(8);
      start = 1'b1;
      k_len = KW'(8);
      tick();
      start = 1'b0;
      bus.in_valid = 1'b1;
      repeat (3) begin
         for (int i = 0; i < N; i++) begin
            bus.a_col[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(1, 255));
            bus.b_row[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(1, 255));
         end
         tick();
      end
      #2 rst = 1'b0;
      #1 check_idle_outputs("midfeed_reset");
      bus.in_valid = 1'b0;
      tick();
      check_idle_outputs("midfeed_reset_held");
      rst = 1'b1;
      tick();
      vectors++;
      if (done_cnt != d0) begin
         miscompares++;
         $display("FAIL midfeed_no_done: got %0d pulses want 0", done_cnt - d0);
      end
      fill_const(1, 2);
      run_job("after_reset", 1, 0, -1, 1'b0);
   endtask

   initial begin
      vectors = 0; miscompares = 0; done_cnt = 0;
      rst = 1'b0; start = 1'b0; k_len = '0;
      bus.in_valid = 1'b0; bus.a_col = '0; bus.b_row = '0; bus.out_ready = 1'b0;
      repeat (2) tick();
      test_reset();
      rst = 1'b1;
      tick();
      test_identity();
      test_max_operands();
      test_bubbles();
      test_out_stall();
      test_start_ignored();
      test_k_zero();
      test_random();
      test_reset_midfeed();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
